demux_1x2_buf: RTL and testbench

Buffered 1-to-2 demultiplexer for 8-bit datapath values. It steers each accepted input word to one of two downstream consumers, for example the register-file write port and the memory write-data path. Each output has its own small FIFO, so a stalled consumer does not lose data and does not block the other consumer. All transfers use a valid/ready handshake on a single clock.

---
 rtl/demux_1x2_buf.sv | 82 ++++++++
 tb/tb_demux_1x2_buf.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_buf.sv
// demux_1x2_buf: steers each accepted byte into one of two independent output
// FIFOs, so a stalled consumer neither loses data nor blocks the other one.
module demux_1x2_buf #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [7:0]    in_data,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out0_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [CW-1:0] out0_count,
    output logic [7:0]    out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [CW-1:0] out1_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    full;
    logic [1:0]    valid;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [7:0]    head  [2];
    logic [CW-1:0] count [2];

    assign ready = {out1_ready, out0_ready};

    // Fullness is registered state, so a same-cycle pop never lets a full
    // FIFO accept: there is no pass-through and no ready->ready path.
    assign in_ready = ~full[in_sel];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] cnt;

        assign push[g]  = in_valid && in_ready && (in_sel == (g != 0));
        assign pop[g]   = valid[g] && ready[g];
        assign valid[g] = (cnt != '0);
        assign full[g]  = (cnt == CW'(DEPTH));
        assign head[g]  = valid[g] ? mem[rd_ptr] : 8'h00;
        assign count[g] = cnt;

        // NOTE: registers are written with non-blocking (<=) so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + AW'(1);
                if (pop[g])  rd_ptr <= rd_ptr + AW'(1);
                case ({push[g], pop[g]})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end

        // NOTE: storage has no reset; stale entries are unreachable once the
        // pointers and count clear, and head is forced to 0 while empty.
        always_ff @(posedge CLK) begin
            if (push[g]) mem[wr_ptr] <= in_data;
        end
    end

    assign out0_data  = head[0];
    assign out0_valid = valid[0];
    assign out0_count = count[0];
    assign out1_data  = head[1];
    assign out1_valid = valid[1];
    assign out1_count = count[1];
endmodule

// File: tb/tb_demux_1x2_buf.sv
// Self-checking bench for demux_1x2_buf: directed vectors plus a random phase,
// with a negedge monitor comparing both outputs against per-output queues.
module tb_demux_1x2_buf;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [7:0]    in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out0_data;
    logic          out0_valid;
    logic          out0_ready;
    logic [CW-1:0] out0_count;
    logic [7:0]    out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [CW-1:0] out1_count;

    demux_1x2_buf #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_count (out0_count),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_count (out1_count)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: outputs are compared against the queues as they stand before
    // this cycle's edge, then words about to be accepted are enqueued.
    always @(negedge CLK) begin
        if (RESET) begin
            check("out0_count", int'(out0_count), exp_q0.size());
            check("out0_valid", int'(out0_valid), int'(exp_q0.size() != 0));
            if (out0_valid && exp_q0.size() != 0) begin
                check("out0_data", int'(out0_data), int'(exp_q0[0]));
                if (out0_ready) void'(exp_q0.pop_front());
            end
            check("out1_count", int'(out1_count), exp_q1.size());
            check("out1_valid", int'(out1_valid), int'(exp_q1.size() != 0));
            if (out1_valid && exp_q1.size() != 0) begin
                check("out1_data", int'(out1_data), int'(exp_q1[0]));
                if (out1_ready) void'(exp_q1.pop_front());
            end
            if (in_valid && in_ready) begin
                if (in_sel) exp_q1.push_back(in_data);
                else        exp_q0.push_back(in_data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out0_valid"}, int'(out0_valid), 0);
        check({tag, "_out1_valid"}, int'(out1_valid), 0);
        check({tag, "_out0_data"},  int'(out0_data),  0);
        check({tag, "_out1_data"},  int'(out1_data),  0);
        check({tag, "_out0_count"}, int'(out0_count), 0);
        check({tag, "_out1_count"}, int'(out1_count), 0);
        in_sel = 1'b0;
        #0.1;
        check({tag, "_in_ready_sel0"}, int'(in_ready), 1);
        in_sel = 1'b1;
        #0.1;
        check({tag, "_in_ready_sel1"}, int'(in_ready), 1);
    endtask

    task automatic drain(input string tag);
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (DEPTH + 3) tick();
        check({tag, "_q0_left"}, exp_q0.size(), 0);
        check({tag, "_q1_left"}, exp_q1.size(), 0);
    endtask

    initial begin
        int idx;
        int cyc;
        logic acc;

        RESET      = 1'b0;
        in_data    = 8'h00;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #2;
        check_reset_outputs("por");
        #20;
        RESET = 1'b1;
        tick();

        // Steering and 1-cycle latency with both consumers ready.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_data = 8'hA5; in_sel = 1'b0; in_valid = 1'b1;
        tick();
        in_data = 8'h3C; in_sel = 1'b1;
        check("steer_out0_valid", int'(out0_valid), 1);
        check("steer_out0_data",  int'(out0_data),  'hA5);
        tick();
        in_valid = 1'b0;
        check("steer_out1_valid", int'(out1_valid), 1);
        check("steer_out1_data",  int'(out1_data),  'h3C);
        check("steer_out0_once",  int'(out0_valid), 0);
        tick();
        check("steer_out1_once",  int'(out1_valid), 0);

        // Fill FIFO 0 with the consumer stalled.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_sel = 1'b0; in_valid = 1'b1;
        in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        in_data = 8'h03;
        #1;
        check("fill_in_ready_sel0", int'(in_ready), 0);
        tick();
        check("fill_count0", int'(out0_count), 2);
        in_sel = 1'b1; in_data = 8'h77;
        #1;
        check("fill_in_ready_sel1", int'(in_ready), 1);
        tick();
        check("fill_count1", int'(out1_count), 1);

        // Full FIFO with a simultaneous pop: the word waits one cycle.
        in_sel = 1'b0; in_data = 8'h04; out0_ready = 1'b1;
        #1;
        check("fullpop_in_ready", int'(in_ready), 0);
        tick();
        check("fullpop_count_a", int'(out0_count), 1);
        out0_ready = 1'b0;
        tick();
        check("fullpop_count_b", int'(out0_count), 2);
        drain("fullpop");

        // Stream 10..17 with a 1-on/1-off consumer, crossing pointer wrap.
        idx = 0;
        cyc = 0;
        in_sel = 1'b0;
        while (idx < 8 && cyc < 100) begin
            in_data    = 8'h10 + 8'(idx);
            in_valid   = 1'b1;
            out0_ready = cyc[0];
            #1;
            acc = in_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        check("wrap_stream_done", idx, 8);
        drain("wrap");

        // Full-rate drain: one push and one pop per cycle keeps count at 1.
        out0_ready = 1'b1;
        in_sel     = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'h20 + 8'(i);
            tick();
            check("fullrate_count", int'(out0_count), 1);
        end
        drain("fullrate");

        // Reset mid-operation with both FIFOs holding data.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid = 1'b1;
        in_sel = 1'b0; in_data = 8'hAA; tick();
        in_sel = 1'b1; in_data = 8'hBB; tick();
        in_sel = 1'b0; in_data = 8'hCC; tick();
        in_valid = 1'b0;
        check("midrst_pre_count0", int'(out0_count), 2);
        #2;
        RESET = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check_reset_outputs("midrst");
        #2;
        RESET = 1'b1;
        tick();
        check("midrst_post_count0", int'(out0_count), 0);

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = 8'($urandom);
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
